mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width.
REQ-002 Parameter DATA_W, default 32, data word width.
REQ-003 Parameter DEPTH, default 64, number of words, power of two, DEPTH <= 2**ADDR_W.
REQ-004 Parameter WAIT_CYCLES, default 2, wait states between accept and response, range 0..15.
REQ-005 clk  input  1  single clock, all logic on rising edge.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 req_valid  input  1  controller presents a request.
REQ-008 req_we  input  1  1 = write, 0 = read.
REQ-009 req_addr  input  ADDR_W  word address.
REQ-010 req_wdata  input  DATA_W  write data.
REQ-011 req_ready  output  1  responder can accept a request this cycle.
REQ-012 resp_valid  output  1  one-cycle completion pulse.
REQ-013 resp_rdata  output  DATA_W  read data, qualified by resp_valid.
REQ-014 resp_err  output  1  out-of-range access flag, qualified by resp_valid (MEM_ERR_EN only).

Function
REQ-015 Memory responder for the multicycle controller; FSM states IDLE, WAIT, RESP, encoded in 2 bits.
REQ-016 req_ready SHALL be 1 only in IDLE; accept = req_valid && req_ready.
REQ-017 On accept, req_we, req_addr and req_wdata SHALL be captured; later input changes are ignored until the next accept.
REQ-018 IDLE -> WAIT on accept when WAIT_CYCLES > 0, loading the wait counter with WAIT_CYCLES-1; IDLE -> RESP on accept when WAIT_CYCLES == 0.
REQ-019 WAIT SHALL decrement the counter each cycle and go to RESP on the cycle the counter reads 0.
REQ-020 RESP SHALL last exactly one cycle with resp_valid=1, then go to IDLE; no backpressure.
REQ-021 Latency: resp_valid SHALL assert WAIT_CYCLES+1 cycles after the accept edge.
REQ-022 A write SHALL commit to storage on the edge entering RESP; a read in RESP SHALL return the word currently stored at the captured address.
REQ-023 For a write response, resp_rdata SHALL be 0.
REQ-024 Outside RESP, resp_valid=0 and resp_rdata=0.
REQ-025 req_valid held high through RESP is not accepted until IDLE, so back-to-back requests have one idle cycle between them (minimum spacing WAIT_CYCLES+2).

Reset
REQ-026 rst SHALL force IDLE, counter 0, req_ready=1 on the following cycle, resp_valid=0, resp_rdata=0, resp_err=0.
REQ-027 rst during WAIT or RESP SHALL abort the request; a write not yet committed SHALL NOT commit, and no response pulse is issued.
REQ-028 Storage contents SHALL NOT be cleared by rst.

Configuration
REQ-029 Macro MEM_ERR_EN: when defined, resp_err exists; req_addr >= DEPTH yields no write, resp_rdata=0 and resp_err=1 in RESP, with unchanged latency.
REQ-030 Without MEM_ERR_EN, resp_err is absent and the address SHALL be reduced modulo DEPTH (low log2(DEPTH) bits).

Structure
REQ-031 Package mem_pkg SHALL hold the state encoding constants (IDLE, WAIT, RESP) and the WAIT_CYCLES maximum.
REQ-032 Storage SHALL be the sub-module mem_array (DEPTH x DATA_W, synchronous write, combinational read, no reset).

Verification
REQ-033 With WAIT_CYCLES=2, write 0xDEADBEEF to addr 5, then read addr 5 -> resp_valid exactly 3 cycles after each accept; read returns 0xDEADBEEF and write response rdata is 0.
REQ-034 With WAIT_CYCLES=0, read -> resp_valid on the cycle after accept; req_ready=0 during RESP.
REQ-035 req_valid held high continuously with WAIT_CYCLES=2 -> accepts every 4 cycles, and each resp_valid pulse is one cycle wide.
REQ-036 rst asserted mid-WAIT of a write of 0x12345678 to addr 3 -> no resp_valid; a later read of addr 3 returns the prior value.
REQ-037 MEM_ERR_EN with DEPTH=64: write to addr 70 -> resp_err=1 and no storage change; without the macro, addr 70 aliases addr 6.
REQ-038 Input changes on req_addr/req_wdata during WAIT -> the captured values are used.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared constants for the memory responder: FSM state encoding and
// wait-state counter sizing. Optional feature macro: MEM_ERR_EN.
package mem_pkg;

    // FSM state encoding (2 bits)
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Largest supported number of wait states and the counter width it implies
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle controller (master) and the
// memory responder (slave). resp_err is present only when MEM_ERR_EN is defined.
//
// Handshake: a request is accepted on a rising edge where req_valid and
// req_ready are both 1; req_we/req_addr/req_wdata are sampled on that edge
// only. resp_valid is a one-cycle pulse with no backpressure; resp_rdata and
// resp_err are meaningful only while resp_valid is 1 (resp_rdata is 0 otherwise).
interface mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req_valid;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              req_ready;
    logic              resp_valid;
    logic [DATA_W-1:0] resp_rdata;
`ifdef MEM_ERR_EN
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
`else
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
`endif
endinterface

// File: rtl/mem_array.sv
// Word storage for the memory responder: DEPTH x DATA_W, synchronous write,
// combinational read, contents are never reset.
module mem_array #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 32,
    parameter int IDX_W  = 6
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Write port: one word per cycle when enabled
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory responder for the multicycle controller: accepts one request in
// IDLE, waits WAIT_CYCLES cycles, then issues a one-cycle response.
// Optional feature macro: MEM_ERR_EN (out-of-range detection, resp_err).
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    mem_responder_if.slave  bus,
    output logic [1:0]      o_dbg_state
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    logic [1:0]        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic [1:0]        w_next_state;
    logic              w_accept;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_oor;
    logic              w_commit;
    logic [DATA_W-1:0] w_rdata;

    assign w_accept = bus.req_valid && (r_state == ST_IDLE);

    // With zero wait states the write commits on the accept edge itself, so
    // the live bus is used in IDLE and the captured copy everywhere else.
    assign w_sel_we    = (r_state == ST_IDLE) ? bus.req_we    : r_we;
    assign w_sel_addr  = (r_state == ST_IDLE) ? bus.req_addr  : r_addr;
    assign w_sel_wdata = (r_state == ST_IDLE) ? bus.req_wdata : r_wdata;

`ifdef MEM_ERR_EN
    assign w_oor = ({1'b0, w_sel_addr} >= (ADDR_W + 1)'(DEPTH));
`else
    // Address wraps modulo DEPTH; upper bits are intentionally ignored
    assign w_oor = 1'b0;
    if (ADDR_W > IDX_W) begin : g_addr_hi
        logic w_unused_addr_hi;
        assign w_unused_addr_hi = ^w_sel_addr[ADDR_W-1:IDX_W];
    end
`endif

    // Next-state decode for IDLE -> (WAIT) -> RESP -> IDLE
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_next_state = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Writes land on the edge entering RESP; a reset on that edge cancels them
    assign w_commit = !rst && (w_next_state == ST_RESP) && w_sel_we && !w_oor;

    // State, wait counter and request capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_accept) begin
                r_we    <= bus.req_we;
                r_addr  <= bus.req_addr;
                r_wdata <= bus.req_wdata;
                r_cnt   <= CNT_LOAD;
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

    mem_array #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W)
    ) u_mem_array (
        .clk     (clk),
        .i_we    (w_commit),
        .i_waddr (w_sel_addr[IDX_W-1:0]),
        .i_wdata (w_sel_wdata),
        .i_raddr (r_addr[IDX_W-1:0]),
        .o_rdata (w_rdata)
    );

    assign bus.req_ready  = (r_state == ST_IDLE);
    assign bus.resp_valid = (r_state == ST_RESP);
    assign bus.resp_rdata = ((r_state == ST_RESP) && !r_we && !w_oor) ? w_rdata : '0;
`ifdef MEM_ERR_EN
    assign bus.resp_err   = (r_state == ST_RESP) && w_oor;
`endif

    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder: a WAIT_CYCLES=2 instance driven with
// randomized requests against a reference memory model, plus a WAIT_CYCLES=0
// instance for zero-wait timing. Honours MEM_ERR_EN when defined.
module tb_mem_responder;

    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int WC    = 2;
`ifdef MEM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) bus2 ();
    mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) busz ();
    logic [1:0] dbg2;
    logic [1:0] dbgz;

    mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .rst(rst), .bus(bus2), .o_dbg_state(dbg2)
    );

    mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_z (
        .clk(clk), .rst(rst), .bus(busz), .o_dbg_state(dbgz)
    );

    // ---------------- scoreboard state ----------------
    int n_tests = 0;
    int n_fail  = 0;
    bit mon_en  = 1'b0;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q[$];
    int            exp_cyc_q[$];
    bit            exp_err_q[$];

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: a word array indexed by address modulo DEPTH; with the
    // error feature, addresses at or above DEPTH neither write nor read.
    task automatic model_push(input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input int acc_cyc);
        int            idx;
        bit            oor;
        logic [DW-1:0] d;
        idx = int'(addr) % DEPTH;
        oor = ERR_EN && (int'(addr) >= DEPTH);
        d   = '0;
        if (we) begin
            if (!oor) ref_mem[idx] = wdata;
        end else if (!oor) begin
            d = ref_mem[idx];
        end
        exp_q.push_back(d);
        exp_cyc_q.push_back(acc_cyc + WC);
        exp_err_q.push_back(oor);
    endtask

    // ---------------- driver tasks ----------------
    // Presents a request, waits (bounded) for acceptance, records the
    // expectation, then scrambles the bus while the responder is busy.
    task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input bit hold, output int acc_cyc);
        int n;
        @(negedge clk);
        bus2.req_valid = 1'b1;
        bus2.req_we    = we;
        bus2.req_addr  = addr;
        bus2.req_wdata = wdata;
        n = 0;
        while (!bus2.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!bus2.req_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles", n);
            bus2.req_valid = 1'b0;
            acc_cyc = -1;
            return;
        end
        acc_cyc = cyc + 1;
        model_push(we, addr, wdata, acc_cyc);
        @(negedge clk);
        bus2.req_valid = hold;
        bus2.req_we    = 1'($urandom_range(0, 1));
        bus2.req_addr  = AW'($urandom_range(0, 255));
        bus2.req_wdata = $urandom;
    endtask

    // Starts a write, then resets before it can respond; delay 1 puts the
    // reset on the edge that would have committed it.
    task automatic abort_write(input logic [AW-1:0] addr, input logic [DW-1:0] wdata, input int delay);
        int n;
        @(negedge clk);
        bus2.req_valid = 1'b1;
        bus2.req_we    = 1'b1;
        bus2.req_addr  = addr;
        bus2.req_wdata = wdata;
        n = 0;
        while (!bus2.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        bus2.req_valid = 1'b0;
        repeat (delay) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_bit("abort_ready", bus2.req_ready, 1'b1);
        check_bit("abort_no_resp", bus2.resp_valid, 1'b0);
    endtask

    // Zero-wait instance: response must appear in the cycle right after accept
    task automatic zop(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [DW-1:0] exp);
        @(negedge clk);
        busz.req_valid = 1'b1;
        busz.req_we    = we;
        busz.req_addr  = addr;
        busz.req_wdata = wdata;
        check_bit("z_ready_idle", busz.req_ready, 1'b1);
        @(negedge clk);
        busz.req_valid = 1'b0;
        busz.req_addr  = AW'($urandom_range(0, 255));
        busz.req_wdata = $urandom;
        check_bit("z_resp_valid", busz.resp_valid, 1'b1);
        check_bit("z_ready_in_resp", busz.req_ready, 1'b0);
        check("z_rdata", busz.resp_rdata, exp);
        @(negedge clk);
        check_bit("z_valid_after", busz.resp_valid, 1'b0);
        check_bit("z_ready_after", busz.req_ready, 1'b1);
    endtask

    // ---------------- monitor ----------------
    logic [DW-1:0] mon_d;
    int            mon_c;
    bit            mon_e;

    // Pops one expectation per response pulse; outside responses rdata must be 0
    always @(negedge clk) begin
        if (mon_en) begin
            if (bus2.resp_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_resp: resp_valid=1 with no request pending at cycle %0d", cyc);
                end else begin
                    mon_d = exp_q.pop_front();
                    mon_c = exp_cyc_q.pop_front();
                    mon_e = exp_err_q.pop_front();
                    check("resp_rdata", bus2.resp_rdata, mon_d);
                    check_int("resp_latency", cyc, mon_c);
                    check_bit("ready_in_resp", bus2.req_ready, 1'b0);
`ifdef MEM_ERR_EN
                    check_bit("resp_err", bus2.resp_err, mon_e);
`endif
                end
            end else begin
                check("idle_rdata", bus2.resp_rdata, '0);
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    int acc;
    int prev_acc;
    int n_wait;
    logic [DW-1:0] zdata [4];

    initial begin
        bus2.req_valid = 1'b0;
        bus2.req_we    = 1'b0;
        bus2.req_addr  = '0;
        bus2.req_wdata = '0;
        busz.req_valid = 1'b0;
        busz.req_we    = 1'b0;
        busz.req_addr  = '0;
        busz.req_wdata = '0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_bit("reset_ready", bus2.req_ready, 1'b1);
        check_bit("reset_valid", bus2.resp_valid, 1'b0);
        check("reset_rdata", bus2.resp_rdata, '0);
`ifdef MEM_ERR_EN
        check_bit("reset_err", bus2.resp_err, 1'b0);
`endif
        rst = 1'b0;
        mon_en = 1'b1;

        // Fill storage so every later read has a known expectation
        for (int i = 0; i < DEPTH; i++) begin
            issue(1'b1, AW'(i), $urandom, 1'b0, acc);
        end

        // Write then read back a known word
        issue(1'b1, 8'd5, 32'hDEADBEEF, 1'b0, acc);
        issue(1'b0, 8'd5, 32'h0, 1'b0, acc);

        // Address 70: aliases 6 without the error feature, rejected with it
        issue(1'b1, 8'd70, 32'hCAFEF00D, 1'b0, acc);
        issue(1'b0, 8'd6, 32'h0, 1'b0, acc);
        issue(1'b0, 8'd70, 32'h0, 1'b0, acc);

        // Aborted writes must not disturb the stored word
        issue(1'b1, 8'd3, 32'hAAAA5555, 1'b0, acc);
        abort_write(8'd3, 32'h12345678, 0);
        issue(1'b0, 8'd3, 32'h0, 1'b0, acc);
        abort_write(8'd3, 32'h12345678, 1);
        issue(1'b0, 8'd3, 32'h0, 1'b0, acc);

        // req_valid held high: accepts spaced WAIT_CYCLES+2 apart
        prev_acc = 0;
        for (int k = 0; k < 4; k++) begin
            issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)), $urandom, (k < 3), acc);
            if (k > 0) check_int("hold_spacing", acc - prev_acc, WC + 2);
            prev_acc = acc;
        end

        // Randomized traffic with random idle gaps
        repeat (120) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 255)), $urandom, 1'b0, acc);
        end

        // Drain outstanding responses (bounded)
        n_wait = 0;
        while (exp_q.size() != 0 && n_wait < 40) begin
            @(negedge clk);
            n_wait++;
        end
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses never arrived", exp_q.size());
        end
        mon_en = 1'b0;

        // Zero-wait-state instance
        for (int i = 0; i < 4; i++) begin
            zdata[i] = $urandom;
            zop(1'b1, AW'(i), zdata[i], 32'h0);
        end
        for (int i = 0; i < 4; i++) begin
            zop(1'b0, AW'(i), 32'h0, zdata[i]);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
